// File: rtl/sdram_ctrlmod.sv
// sdram_ctrlmod
//   Control stage in front of the SDRAM function module. Runs the power-up
//   init call, issues a periodic auto-refresh, and arbitrates user write/read
//   requests onto the one-hot call/done handshake of the function module.
//
//   Optional build macro: SDRAM_CTRL_OVR_EN adds the sticky oRefOvr flag.
//
// Ports
//   CLOCK    in   1  system clock, rising edge
//   RESET    in   1  asynchronous reset, active low
//   iCall    in   2  user requests, [1] write, [0] read; level, held until oDone
//   oDone    out  1  one-clock pulse when the granted user request completes
//   oCall    out  4  one-hot call to function module: [3] wr [2] rd [1] ref [0] init
//   iDone    in   1  one-clock completion pulse from the function module
//   oRefOvr  out  1  (SDRAM_CTRL_OVR_EN only) a refresh interval expired
//                    while the previous refresh was still pending
//
// State | meaning
// INIT  | init call held until the function module reports done
// IDLE  | arbitrate: pending refresh > write > read
// REF   | auto-refresh call held until iDone
// WR    | write call held until iDone
// RD    | read call held until iDone
// DONE  | oDone high for this single clock
// GAP   | one quiet clock so a dropped request is never re-granted
module sdram_ctrlmod #(
    parameter logic [10:0] TREF = 11'd1040
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [1:0] iCall,
    output logic       oDone,
    output logic [3:0] oCall,
    input  logic       iDone
`ifdef SDRAM_CTRL_OVR_EN
    ,
    output logic       oRefOvr
`endif
);

    typedef enum logic [2:0] {
        INIT = 3'd0,
        IDLE = 3'd1,
        REF  = 3'd2,
        WR   = 3'd3,
        RD   = 3'd4,
        DONE = 3'd5,
        GAP  = 3'd6
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [3:0]  nextCall;
    logic        nextDone;
    logic [10:0] refCount;
    logic        refPend;
    logic        refEn;
    logic        refHit;
    logic        enterRef;

    // The interval timer only runs once init has finished.
    assign refEn    = (state != INIT);
    assign refHit   = refEn && (refCount == (TREF - 11'd1));
    assign enterRef = (state == IDLE) && (nextState == REF);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            refCount <= 11'd0;
        end else if (!refEn || refHit) begin
            refCount <= 11'd0;
        end else begin
            refCount <= refCount + 11'd1;
        end
    end

    // A new expiry wins over the clear so it is never lost.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            refPend <= 1'b0;
        end else if (refHit) begin
            refPend <= 1'b1;
        end else if (enterRef) begin
            refPend <= 1'b0;
        end
    end

`ifdef SDRAM_CTRL_OVR_EN
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            oRefOvr <= 1'b0;
        end else if (refHit && refPend) begin
            oRefOvr <= 1'b1;
        end
    end
`endif

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= INIT;
            oCall <= 4'b0000;
            oDone <= 1'b0;
        end else begin
            state <= nextState;
            oCall <= nextCall;
            oDone <= nextDone;
        end
    end

    // The call is dropped on the edge that samples iDone, so the function
    // module sees its call low when it returns to its first step.
    always_comb begin
        nextState = state;
        nextCall  = 4'b0000;
        nextDone  = 1'b0;
        case (state)
            INIT: begin
                nextCall = 4'b0001;
                if (iDone) begin
                    nextCall  = 4'b0000;
                    nextState = IDLE;
                end
            end
            IDLE: begin
                if (refPend) begin
                    nextCall  = 4'b0010;
                    nextState = REF;
                end else if (iCall[1]) begin
                    nextCall  = 4'b1000;
                    nextState = WR;
                end else if (iCall[0]) begin
                    nextCall  = 4'b0100;
                    nextState = RD;
                end
            end
            REF: begin
                nextCall = 4'b0010;
                if (iDone) begin
                    nextCall  = 4'b0000;
                    nextState = GAP;
                end
            end
            WR: begin
                nextCall = 4'b1000;
                if (iDone) begin
                    nextCall  = 4'b0000;
                    nextDone  = 1'b1;
                    nextState = DONE;
                end
            end
            RD: begin
                nextCall = 4'b0100;
                if (iDone) begin
                    nextCall  = 4'b0000;
                    nextDone  = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = GAP;
            end
            GAP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_ctrlmod.sv
// Testbench for sdram_ctrlmod. A function-module model answers each call with
// iDone after a chosen delay; the stimulus plans every expected call/done event
// from the refresh-interval arithmetic and pushes it to a queue, and a monitor
// compares each observed oCall change and oDone pulse against that queue.
module tb_sdram_ctrlmod;

    localparam logic [10:0] TREF = 11'd600;
    localparam int TR = 600;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [1:0] iCall;
    logic       oDone;
    logic [3:0] oCall;
    logic       iDone;
`ifdef SDRAM_CTRL_OVR_EN
    logic       oRefOvr;
`endif

    sdram_ctrlmod #(.TREF(TREF)) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .iCall(iCall),
        .oDone(oDone),
        .oCall(oCall),
        .iDone(iDone)
`ifdef SDRAM_CTRL_OVR_EN
        ,
        .oRefOvr(oRefOvr)
`endif
    );

    initial forever #5 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         kind;   // 0 call on, 1 call off, 2 done pulse
        logic [3:0] val;
        int         at;
    } ev_t;

    ev_t expQ[$];
    int  userDelays[$];
    int  initDelay = 20;
    int  refDelay  = 6;
    bit  spur      = 1'b0;
    bit  monEn     = 1'b1;

    // reference model: edge of init exit, first free decision edge, next
    // unserved expiry edge
    int X;
    int F;
    int nextExp;

    function automatic int maxi(int a, int b);
        return (a > b) ? a : b;
    endfunction

    task automatic pushEv(int kind, logic [3:0] val, int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.at   = at;
        expQ.push_back(e);
    endtask

    task automatic serveRef(int t);
        pushEv(0, 4'b0010, t);
        pushEv(1, 4'b0000, t + refDelay);
        F = t + refDelay + 2;
        while (nextExp <= t - 1) nextExp += TR;
    endtask

    // Request visible at edge r, completes dl edges after its grant.
    task automatic planOp(int r, bit isW, int dl);
        int d;
        int rd;
        while (1) begin
            d  = maxi(F, r);
            rd = maxi(F, nextExp + 1);
            if (rd <= d) serveRef(rd);
            else break;
        end
        pushEv(0, isW ? 4'b1000 : 4'b0100, d);
        pushEv(1, 4'b0000, d + dl);
        pushEv(2, 4'b0000, d + dl);
        F = d + dl + 3;
        userDelays.push_back(dl);
    endtask

    task automatic planInit(int rel, int dly);
        initDelay = dly;
        pushEv(0, 4'b0001, rel + 1);
        pushEv(1, 4'b0000, rel + 1 + dly);
        X       = rel + 1 + dly;
        F       = X + 1;
        nextExp = X + TR;
    endtask

    task automatic atEdge(int n);
        while (cyc < n) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic checkVal(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic waitDone();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLOCK);
            if (oDone === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no oDone within 4000 clocks (cycle %0d)", cyc);
        end
    endtask

    // kind 0 write, 1 read, 2 both held together
    task automatic runOps(int kind, int gap, int d1, int d2, bit sp);
        int r;
        r = cyc + gap + 1;
        if (kind == 0) planOp(r, 1'b1, d1);
        else if (kind == 1) planOp(r, 1'b0, d1);
        else begin
            planOp(r, 1'b1, d1);
            planOp(r, 1'b0, d2);
        end
        atEdge(r - 1);
        iCall = (kind == 0) ? 2'b10 : (kind == 1) ? 2'b01 : 2'b11;
        waitDone();
        if (kind == 2) begin
            iCall[1] = 1'b0;
            waitDone();
        end
        iCall = 2'b00;
        if (sp) spur = 1'b1;
    endtask

    // function-module model
    int         fmRem = 0;
    logic [3:0] fmPrev = 4'b0000;
    initial begin
        iDone = 1'b0;
        forever begin
            @(negedge CLOCK);
            iDone = 1'b0;
            if (!RESET) begin
                fmRem  = 0;
                fmPrev = 4'b0000;
            end else begin
                if (oCall != 4'b0000 && fmPrev == 4'b0000) begin
                    if (oCall[0]) fmRem = initDelay;
                    else if (oCall[1]) fmRem = refDelay;
                    else if (userDelays.size() > 0) fmRem = userDelays.pop_front();
                    else fmRem = 5;
                end
                fmPrev = oCall;
                if (fmRem > 0) begin
                    fmRem--;
                    if (fmRem == 0) iDone = 1'b1;
                end else if (spur) begin
                    iDone = 1'b1;
                    spur  = 1'b0;
                end
            end
        end
    end

    // monitor / scoreboard
    logic [3:0] monPrev = 4'b0000;

    task automatic compareEv(int kind, logic [3:0] val, int at);
        ev_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected kind=%0d val=%b at=%0d", kind, val, at);
        end else begin
            e = expQ.pop_front();
            if (e.kind != kind || e.val != val || e.at != at) begin
                errors++;
                $display("FAIL event: got kind=%0d val=%b at=%0d expected kind=%0d val=%b at=%0d",
                         kind, val, at, e.kind, e.val, e.at);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge CLOCK);
            if (monEn) begin
                checks++;
                if ($countones(oCall) > 1) begin
                    errors++;
                    $display("FAIL onehot: oCall=%b expected at most one bit (cycle %0d)", oCall, cyc);
                end
                if (oCall !== monPrev) begin
                    compareEv((oCall != 4'b0000) ? 0 : 1, oCall, cyc);
                    monPrev = oCall;
                end
                if (oDone === 1'b1) compareEv(2, 4'b0000, cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    int rel;
    int lim;
    int base;
    int d;
    int r;
    int t;

    initial begin
        RESET = 1'b1;
        iCall = 2'b00;
        #2 RESET = 1'b0;
        atEdge(3);
        checkVal("reset_oCall", oCall, 0);
        checkVal("reset_oDone", oDone, 0);
`ifdef SDRAM_CTRL_OVR_EN
        checkVal("reset_oRefOvr", oRefOvr, 0);
`endif

        // write held through init: granted only after init completes
        iCall = 2'b10;
        @(negedge CLOCK);
        rel = cyc;
        planInit(rel, 20);
        planOp(rel + 1, 1'b1, 10);
        RESET = 1'b1;
        waitDone();
        iCall = 2'b00;

        // simultaneous write + read
        runOps(2, 3, 10, 10, 1'b1);

        // idle: two refresh intervals
        lim = cyc + 1300;
        while (maxi(F, nextExp + 1) < lim) serveRef(maxi(F, nextExp + 1));
        atEdge(lim);

        // write granted at counter 550; refresh expires mid-write and must
        // beat the read that is raised while the write runs
        base = maxi(F, cyc + 1) + 20;
        d = X + 550 + TR * ((base - X - 550 + TR - 1) / TR);
        planOp(d, 1'b1, 520);
        planOp(d + 6, 1'b0, 1 + int'($urandom % 30));
        atEdge(d - 1);
        iCall = 2'b10;
        atEdge(d + 5);
        iCall[0] = 1'b1;
        waitDone();
        iCall[1] = 1'b0;
        waitDone();
        iCall = 2'b00;

        for (int i = 0; i < 6; i++)
            runOps(int'($urandom % 3), int'($urandom % 200), 1 + int'($urandom % 60),
                   1 + int'($urandom % 60), bit'($urandom % 2));

        // write stalled across two refresh intervals
`ifdef SDRAM_CTRL_OVR_EN
        checkVal("ovr_before", oRefOvr, 0);
`endif
        runOps(0, 2, 1300, 1, 1'b0);
`ifdef SDRAM_CTRL_OVR_EN
        checkVal("ovr_after_miss", oRefOvr, 1);
`endif
        runOps(1, 5, 8, 1, 1'b0);
`ifdef SDRAM_CTRL_OVR_EN
        checkVal("ovr_sticky", oRefOvr, 1);
`endif

        // reset in the middle of a read
        r = cyc + 10;
        planOp(r, 1'b0, 50);
        void'(expQ.pop_back());
        void'(expQ.pop_back());
        d = F - 53;
        atEdge(r - 1);
        iCall = 2'b01;
        atEdge(d + 10);
        RESET = 1'b0;
        #1;
        checkVal("midreset_oCall", oCall, 0);
        checkVal("midreset_oDone", oDone, 0);
`ifdef SDRAM_CTRL_OVR_EN
        checkVal("midreset_oRefOvr", oRefOvr, 0);
`endif
        pushEv(1, 4'b0000, cyc);
        iCall = 2'b00;
        repeat (3) @(negedge CLOCK);
        rel = cyc;
        planInit(rel, 5 + int'($urandom % 20));
        RESET = 1'b1;

        for (int i = 0; i < 3; i++)
            runOps(int'($urandom % 3), int'($urandom % 150), 1 + int'($urandom % 40),
                   1 + int'($urandom % 40), bit'($urandom % 2));

        // one more refresh, then stop observing
        t = maxi(F, nextExp + 1);
        serveRef(t);
        atEdge(F + 2);
        monEn = 1'b0;
        checkVal("events_left", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
